mips_multicycle_core: RTL

Parametrised multicycle successor to the single-cycle MIPS machine. It runs the same word-addressed MIPS subset on a multi-state FSM. Instruction and data accesses share one external memory port with a req/ready handshake, so wait states are supported. It holds the 32×32 register file and the IR/A/B/ALUOut/MDR holding registers, and exposes retire/write-back debug ports for the verification bench.

---
 rtl/mips_multicycle_core.sv | 127 ++++++++++++
 1 files changed

// File: rtl/mips_multicycle_core.sv
// mips_multicycle_core: multicycle MIPS-subset core sharing one req/ready memory port for fetch and data
// Ports: clk, rst (async, active-low); mem_req/mem_we/mem_addr/mem_wdata out, mem_rdata/mem_ready in;
//        debug: pc, retire pulse, wb_en/wb_reg/wb_data register-file write, halted (sticky on illegal op).
module mips_multicycle_core #(
  parameter int          ADDR_W   = 10,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [31:0]       pc,
  output logic              retire,
  output logic              wb_en,
  output logic [4:0]        wb_reg,
  output logic [31:0]       wb_data,
  output logic              halted
);
  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, EXEC_R, WB_R, EXEC_I, WB_I, MEMADR,
    MEM_RD, WB_MEM, MEM_WR, BRANCH, JUMP, HALT
  } state_t;
  state_t      state_q, dec_next;
  logic [31:0] pc_q, ir_q, a_q, b_q, alu_q, mdr_q;
  logic [31:0] rf_q [32];
  logic [5:0]  op, fn;
  logic [4:0]  rs, rt, rd, wb_dst;
  logic [31:0] sext, zext, r_res, i_res, wb_val;
  logic        r_ok;
  assign op   = ir_q[31:26];
  assign fn   = ir_q[5:0];
  assign rs   = ir_q[25:21];
  assign rt   = ir_q[20:16];
  assign rd   = ir_q[15:11];
  assign sext = {{16{ir_q[15]}}, ir_q[15:0]};
  assign zext = {16'd0, ir_q[15:0]};
  always_comb begin
    r_ok  = fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
    r_res = fn == 6'h20 ? a_q + b_q :
            fn == 6'h22 ? a_q - b_q :
            fn == 6'h24 ? a_q & b_q :
            fn == 6'h25 ? a_q | b_q :
            fn == 6'h27 ? ~(a_q | b_q) :
                          {31'd0, $signed(a_q) < $signed(b_q)};
    i_res = op == 6'h08 ? a_q + sext :
            op == 6'h0A ? {31'd0, $signed(a_q) < $signed(sext)} :
            op == 6'h0C ? a_q & zext :
                          a_q | zext;
    dec_next = op == 6'h00 ? (r_ok ? EXEC_R : HALT) :
               op inside {6'h08, 6'h0A, 6'h0C, 6'h0D} ? EXEC_I :
               op inside {6'h23, 6'h2B} ? MEMADR :
               op inside {6'h04, 6'h05} ? BRANCH :
               op == 6'h02 ? JUMP : HALT;
  end
  assign mem_req   = state_q inside {FETCH, MEM_RD, MEM_WR};
  assign mem_we    = state_q == MEM_WR;
  assign mem_addr  = state_q == FETCH ? pc_q[ADDR_W-1:0] : mem_req ? alu_q[ADDR_W-1:0] : '0;
  assign mem_wdata = mem_we ? b_q : '0;
  assign pc        = pc_q;
  // a store retires in the cycle its memory write is accepted
  assign retire    = state_q inside {WB_R, WB_I, WB_MEM, BRANCH, JUMP} || (mem_we && mem_ready);
  assign wb_dst    = state_q == WB_R ? rd : rt;
  assign wb_val    = state_q == WB_MEM ? mdr_q : alu_q;
  assign wb_en     = state_q inside {WB_R, WB_I, WB_MEM} && wb_dst != 5'd0;
  assign wb_reg    = wb_en ? wb_dst : '0;
  assign wb_data   = wb_en ? wb_val : '0;
  assign halted    = state_q == HALT;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      alu_q   <= '0;
      mdr_q   <= '0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      if (wb_en) rf_q[wb_dst] <= wb_val;
      case (state_q)
        IDLE: state_q <= FETCH;
        FETCH: if (mem_ready) begin
          ir_q    <= mem_rdata;
          pc_q    <= pc_q + 32'd1;
          state_q <= DECODE;
        end
        DECODE: begin
          a_q     <= rf_q[rs];
          b_q     <= rf_q[rt];
          alu_q   <= pc_q + sext;
          state_q <= dec_next;
        end
        EXEC_R: begin
          alu_q   <= r_res;
          state_q <= WB_R;
        end
        EXEC_I: begin
          alu_q   <= i_res;
          state_q <= WB_I;
        end
        WB_R, WB_I, WB_MEM: state_q <= FETCH;
        MEMADR: begin
          alu_q   <= a_q + sext;
          state_q <= op == 6'h23 ? MEM_RD : MEM_WR;
        end
        MEM_RD: if (mem_ready) begin
          mdr_q   <= mem_rdata;
          state_q <= WB_MEM;
        end
        MEM_WR: if (mem_ready) state_q <= FETCH;
        BRANCH: begin
          if ((a_q == b_q) == (op == 6'h04)) pc_q <= alu_q;
          state_q <= FETCH;
        end
        JUMP: begin
          pc_q    <= {pc_q[31:26], ir_q[25:0]};
          state_q <= FETCH;
        end
        default: state_q <= HALT;
      endcase
    end
  end
endmodule
